sw_debounce: RTL
================

Name: sw_debounce

Overview:
- Input conditioner for the board slide switches and the enable switch.
- Synchronises each raw switch line to the system clock, debounces it, and presents a glitch-free stable vector plus per-bit edge pulses.
- Sits directly upstream of the 8-to-3 priority encoder / 7-segment display path: its stable outputs feed the encoder data and enable inputs.

Parameters:
- WIDTH, 9, number of switch channels (8 data switches + 1 enable).
- DEB_CYCLES, 1000000, consecutive cycles a synchronised level must persist before it is accepted; legal range 2 to 2^24.
- RST_VAL, 9'h000, value loaded into synchroniser and stable registers on reset.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- sw_raw_i  input  WIDTH  raw asynchronous switch levels.
- sw_o  output  WIDTH  debounced stable switch levels.
- rise_o  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 transition.
- fall_o  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 transition.
- chg_o  output  1  OR of rise_o and fall_o; one-cycle pulse.

Behaviour:
- Reset: clk_i and rst_n_i are the single clock and reset. Reset asserts asynchronously, active-low. While rst_n_i=0, these values hold:
  - both synchroniser stages = RST_VAL
  - sw_o = RST_VAL
  - all counters = 0
  - rise_o, fall_o, chg_o = 0
- Reset deassertion: no pulse is generated on the first cycle after release.
- Synchroniser: two-flop chain per bit; s[i] is the second-stage output.
- Per-bit debounce counter cnt[i], width $clog2(DEB_CYCLES). On each rising edge:
  - If s[i] == sw_o[i]: cnt[i] <= 0; no pulse.
  - If s[i] != sw_o[i] and cnt[i] < DEB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If s[i] != sw_o[i] and cnt[i] == DEB_CYCLES-1: sw_o[i] <= s[i]; cnt[i] <= 0; rise_o[i] or fall_o[i] <= 1 for exactly that cycle, per direction.
- Latency: a raw level that is stable from before edge 0 updates sw_o at edge 2+DEB_CYCLES.
- Pulse timing: the edge pulse is registered and is high in the same cycle sw_o first shows the new value.
- Glitch rejection: any return of s[i] to sw_o[i] before the count completes clears cnt[i]. A pulse train whose high time is < DEB_CYCLES cycles never changes sw_o.
- Channel independence: channels are fully independent. Simultaneous transitions on several bits may pulse in the same cycle; chg_o is a single pulse in that case.
- Counter wrap: cnt never exceeds DEB_CYCLES-1; no wrap-around.
- Reset mid-debounce: the partial count is discarded; sw_o returns to RST_VAL immediately (asynchronous).
- Outputs are registered only; there is no combinational path from sw_raw_i to any output.

Decomposition:
- Shared package sw_pkg holds:
  - SW_WIDTH = 9
  - SW_EN_BIT = 8 (index of the enable switch)
  - SIM_DEB_CYCLES = 4 (simulation debounce length)
  - BOARD_DEB_CYCLES = 1000000
- One natural sub-module: debounce_bit. It contains the 2-flop synchroniser, counter and edge detect for a single channel.
- sw_debounce instantiates WIDTH debounce_bit copies via generate and ORs their pulses into chg_o.

Test Plan (DEB_CYCLES=4, RST_VAL=0):
- Reset mid-count: hold rst_n_i=0 with sw_raw_i=9'h1FF -> sw_o=0, no pulses. Release reset, keep sw_raw_i=0 -> sw_o stays 0, chg_o never asserts.
- Clean rise: sw_raw_i[3] 0->1 before edge 0 -> sw_o=9'h008 after edge 6. rise_o=9'h008 and chg_o=1 for exactly cycle 6. fall_o=0 throughout.
- Glitch rejection: sw_raw_i[0] high for 3 cycles, then low -> sw_o[0] stays 0; rise_o[0] and chg_o never assert.
- Bounce: sw_raw_i[5] toggles 1,0,1,0 on successive cycles, then holds 1 -> sw_o[5] goes to 1 exactly 6 edges after the final 0->1 transition, with a single rise_o[5] pulse.
- Multi-bit simultaneous events: set sw_raw_i=9'h181 from 0, wait for acceptance, then set sw_raw_i=9'h100 -> first a single chg_o pulse with rise_o=9'h181. Then a single chg_o pulse with fall_o=9'h081; sw_o ends at 9'h100.
- Reset during debounce: raise sw_raw_i[2] and assert rst_n_i=0 at cycle 4 for 2 cycles, then release -> sw_o=0 immediately at assertion. After release, sw_o[2]=1 at edge 6 after release, with one rise_o[2] pulse.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared constants for the switch input conditioner.
// Holds the channel count, the enable-switch index and the two debounce lengths
// (short one for simulation, long one for the board clock), plus a helper that
// sizes the per-channel debounce counter.
package sw_pkg;

    localparam int unsigned SW_WIDTH         = 9;
    localparam int unsigned SW_EN_BIT        = 8;
    localparam int unsigned SIM_DEB_CYCLES   = 4;
    localparam int unsigned BOARD_DEB_CYCLES = 1000000;

    // Counter must hold DEB_CYCLES-1; never let the width collapse to zero.
    function automatic int unsigned cnt_width(int unsigned deb_cycles);
        int unsigned w;
        w = $clog2(deb_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-channel switch conditioner: two-flop synchroniser, a decision register,
// a saturating debounce counter and registered rise/fall pulses.
//
// Ports:
//   clk_i     system clock
//   rst_n_i   asynchronous active-low reset
//   raw_i     raw asynchronous switch level
//   stable_o  debounced level
//   rise_o    one-cycle pulse on an accepted 0->1 transition
//   fall_o    one-cycle pulse on an accepted 1->0 transition
module debounce_bit
    import sw_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = SIM_DEB_CYCLES,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned   CW      = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          smp_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // meta_q/sync_q form the synchroniser; smp_q is the registered copy of the
    // synchronised level that the debounce decision compares against, which puts
    // acceptance at edge 2+DEB_CYCLES for a level stable before edge 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q   <= RST_VAL;
            sync_q   <= RST_VAL;
            smp_q    <= RST_VAL;
            stable_q <= RST_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            smp_q    <= sync_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (smp_q == stable_q) begin
            // Any return to the accepted level discards the partial count.
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = smp_q;
            cnt_d    = '0;
            rise_d   = smp_q;
            fall_d   = ~smp_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Input conditioner for the slide switches and the enable switch. Each channel
// is synchronised and debounced independently; the stable vector feeds the
// priority encoder data/enable inputs.
//
// Ports:
//   clk_i     system clock
//   rst_n_i   asynchronous active-low reset
//   sw_raw_i  raw switch levels [WIDTH]
//   sw_o      debounced switch levels [WIDTH]
//   rise_o    per-bit accepted 0->1 pulse [WIDTH]
//   fall_o    per-bit accepted 1->0 pulse [WIDTH]
//   chg_o     any rise/fall pulse this cycle
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned      WIDTH      = SW_WIDTH,
    parameter int unsigned      DEB_CYCLES = BOARD_DEB_CYCLES,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             chg_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_VAL    (RST_VAL[i])
        ) u_debounce_bit (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .raw_i    (sw_raw_i[i]),
            .stable_o (sw_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i])
        );
    end

    // OR of registered pulses only; no path from sw_raw_i.
    assign chg_o = |{rise_o, fall_o};

endmodule
